// File: rtl/vector_pkg.sv
// Shared types for the vector bypass pipeline:
// execution_vector_t {unit, op} plus unit/op enumerations.
package vector_pkg;

  typedef enum logic {
    UNIT_LOGIC = 1'b0,
    UNIT_SHIFT = 1'b1
  } unit_e;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } logic_op_e;

  typedef enum logic [1:0] {
    OP_SLL   = 2'd0,
    OP_SRL   = 2'd1,
    OP_SRA   = 2'd2,
    OP_SPASS = 2'd3
  } shift_op_e;

  typedef struct packed {
    unit_e      unit;
    logic [1:0] op;
  } execution_vector_t;

endpackage

// File: rtl/vector_forward_select.sv
// Per-operand bypass compare and mux.
// Ports: src_addr/src_data (raw operand), s1_*/s2_* producers, operand out.
module vector_forward_select
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic                      s1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0]     s1_data,
  input  logic                      s2_valid,
  input  logic [REG_ADDR_WIDTH-1:0] s2_addr,
  input  logic [DATA_WIDTH-1:0]     s2_data,
  output logic [DATA_WIDTH-1:0]     operand
);

  logic s1_hit;
  logic s2_hit;

  assign s1_hit = s1_valid && (s1_addr == src_addr);
  assign s2_hit = s2_valid && (s2_addr == src_addr);

  // S1 is the younger producer, so it wins.
  always_comb begin
    operand = src_data;
    if (s1_hit) begin
      operand = s1_data;
    end else if (s2_hit) begin
      operand = s2_data;
    end
  end

endmodule

// File: rtl/vector_bypass_pipeline.sv
// Two-stage vector logic/shift pipe (S1 RR/EX, S2 EX/CM) with valid/ready.
// Ports: clock, reset_n, in_* upstream, out_*/vd/vd_addr_out downstream.
// Bypass from S1/S2 to operands is enabled by VECTOR_BYPASS_EN.
module vector_bypass_pipeline
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  execution_vector_t         execution_vector,
  input  logic [DATA_WIDTH-1:0]     vs2,
  input  logic [DATA_WIDTH-1:0]     vs1,
  input  logic [REG_ADDR_WIDTH-1:0] vs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] vs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] vd_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     vd,
  output logic [REG_ADDR_WIDTH-1:0] vd_addr_out
);

  localparam int SHW = $clog2(DATA_WIDTH);

`ifdef VECTOR_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic                      s1_valid;
  execution_vector_t         s1_ev;
  logic [DATA_WIDTH-1:0]     s1_a;
  logic [DATA_WIDTH-1:0]     s1_b;
  logic [REG_ADDR_WIDTH-1:0] s1_vd_addr;

  logic                      s2_valid;
  logic [DATA_WIDTH-1:0]     s2_res;
  logic [REG_ADDR_WIDTH-1:0] s2_vd_addr;

  logic                      s2_load;
  logic                      accept;
  logic [DATA_WIDTH-1:0]     ex_res;
  logic [DATA_WIDTH-1:0]     op_a;
  logic [DATA_WIDTH-1:0]     op_b;
  logic [SHW-1:0]            sh;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  assign out_valid   = s2_valid;
  assign vd          = s2_res;
  assign vd_addr_out = s2_vd_addr;

  assign sh = s1_b[SHW-1:0];

  always_comb begin
    ex_res = s1_a;
    unique case (s1_ev.unit)
      UNIT_LOGIC: begin
        case (logic_op_e'(s1_ev.op))
          OP_AND:  ex_res = s1_a & s1_b;
          OP_OR:   ex_res = s1_a | s1_b;
          OP_XOR:  ex_res = s1_a ^ s1_b;
          OP_PASS: ex_res = s1_a;
        endcase
      end
      UNIT_SHIFT: begin
        case (shift_op_e'(s1_ev.op))
          OP_SLL:   ex_res = s1_a << sh;
          OP_SRL:   ex_res = s1_a >> sh;
          OP_SRA:   ex_res = $unsigned($signed(s1_a) >>> sh);
          OP_SPASS: ex_res = s1_a;
        endcase
      end
    endcase
  end

  // Gating the producer valids removes all bypass
  // paths while keeping timing identical.
  vector_forward_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_vs2 (
    .src_addr(vs2_addr),
    .src_data(vs2),
    .s1_valid(s1_valid && BYPASS),
    .s1_addr (s1_vd_addr),
    .s1_data (ex_res),
    .s2_valid(s2_valid && BYPASS),
    .s2_addr (s2_vd_addr),
    .s2_data (s2_res),
    .operand (op_a)
  );

  vector_forward_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_vs1 (
    .src_addr(vs1_addr),
    .src_data(vs1),
    .s1_valid(s1_valid && BYPASS),
    .s1_addr (s1_vd_addr),
    .s1_data (ex_res),
    .s2_valid(s2_valid && BYPASS),
    .s2_addr (s2_vd_addr),
    .s2_data (s2_res),
    .operand (op_b)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_ev      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_vd_addr <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_ev      <= execution_vector;
      s1_a       <= op_a;
      s1_b       <= op_b;
      s1_vd_addr <= vd_addr;
    end else if (s2_load) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      s2_res     <= '0;
      s2_vd_addr <= '0;
    end else if (s2_load) begin
      s2_valid   <= s1_valid;
      s2_res     <= ex_res;
      s2_vd_addr <= s1_vd_addr;
    end
  end

endmodule
